audio_xfade_mux: RTL
====================

AUDIO_XFADE_MUX -- requirements
Module: audio_xfade_mux

Interface
REQ-001 Parameters (name, default, meaning):
- NUM_SRC, 4, number of stereo PCM sources.
- DATA_W, 24, signed sample width.
- RAMP_BITS, 6, gain resolution; full gain GMAX = 2^RAMP_BITS.
- TIMEOUT, 4096, clk cycles without an active-source strobe before a forced switch.
- SEL_W = clog2(NUM_SRC), derived, not overridable.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock.
- reset_n, in, 1, reset; asynchronous, active-low.
- run, in, 1, block enable.
- select, in, SEL_W, requested source.
- src_valid, in, NUM_SRC, per-source sample strobe; one strobe carries both L and R.
- l_src_data, in, NUM_SRC*DATA_W, flattened left samples; source k occupies [k*DATA_W +: DATA_W].
- r_src_data, in, NUM_SRC*DATA_W, flattened right samples; same packing.
- out_valid, out, 1, one-cycle output strobe.
- l_out, out, DATA_W, left output, signed.
- r_out, out, DATA_W, right output, signed.
- active_sel, out, SEL_W, source currently routed.
- busy, out, 1, high in any state other than PLAY or IDLE.

Function
REQ-003 States: IDLE, FADE_IN, PLAY, FADE_OUT, SWITCH. Gain register g ranges 0..GMAX and is RAMP_BITS+1 bits wide.
REQ-004 Only src_valid[active_sel] is honoured; strobes from other sources are ignored.
REQ-005 Each honoured strobe produces exactly one out_valid, 2 clk after the strobe (2-stage pipeline).
- Stage 1 registers the product data*g.
- Stage 2 registers the product arithmetic-right-shifted by RAMP_BITS and truncated to DATA_W.
REQ-006 With g = GMAX, l_out and r_out SHALL equal the input samples bit-exactly; with g = 0 they SHALL be 0.
REQ-007 The product is signed, DATA_W+RAMP_BITS+2 bits wide, and no saturation is needed.
REQ-008 The sample that uses gain g is the one strobed while g holds that value; g updates on the same strobe, after use.
REQ-009 IDLE to FADE_IN:
- Occurs when run=1 and select < NUM_SRC.
- active_sel loads select; g = 0.
REQ-010 FADE_IN: g increments by 1 per honoured strobe. After the strobe at which g reaches GMAX, the state is PLAY.
REQ-011 PLAY to FADE_OUT: occurs when select != active_sel and select < NUM_SRC. The requested value is latched into pending_sel.
REQ-012 FADE_OUT: g decrements by 1 per honoured strobe. On the strobe at which g reaches 0, the state is SWITCH.
REQ-013 SWITCH lasts one clk. active_sel loads pending_sel, g = 0, then the state is FADE_IN. No output strobe is produced in SWITCH.
REQ-014 A select change during FADE_OUT updates pending_sel only; the fade continues.
REQ-015 Select changes during FADE_IN:
- A change to a value other than active_sel goes to FADE_OUT from the current g, with no jump in g.
- A change back to active_sel is ignored.
REQ-016 A select change during FADE_OUT back to active_sel SHALL go to FADE_IN from the current g.
REQ-017 A select value >= NUM_SRC SHALL be ignored in all states.
REQ-018 Timeout: in FADE_OUT or FADE_IN, if no honoured strobe arrives for TIMEOUT consecutive clk, the state SHALL go to SWITCH.
- From FADE_IN, pending_sel = active_sel.
- The timeout counter clears on every honoured strobe and on every state change.
REQ-019 run=0 (synchronous, any state):
- Next state IDLE, g = 0.
- out_valid = 0; the pipeline is flushed, and in-flight samples are discarded.
- l_out and r_out hold their last values; active_sel holds.
REQ-020 A strobe on the same cycle as a select change is processed with the pre-change state and g; the state transition takes effect on the next clk.
REQ-021 busy is registered and valid in the same cycle as the state register.

Reset
REQ-022 While reset_n=0, asynchronously:
- state = IDLE, g = 0, pending_sel = 0, active_sel = 0.
- out_valid = 0, l_out = 0, r_out = 0, busy = 0.
- Pipeline stages and timeout counter = 0.
REQ-023 Reset asserted mid-fade abandons the fade. After release, the block starts from IDLE per REQ-009.

Verification
REQ-024 Startup fade-in: reset release, run=1, select=1, src1 strobes every 512 clk with L=R=0x400000.
- out_valid comes 2 clk after each strobe.
- Outputs are 0x000000, 0x010000, 0x020000, ...
- From strobe 65 onward the output is 0x400000; busy falls after strobe 64.
REQ-025 Switch: in PLAY on src1, set select=2.
- 64 strobes fade out to 0; SWITCH lasts 1 clk; active_sel becomes 2.
- 64 strobes of src2 fade in.
- The src2 data ramp is exact and the sample value -1 (0xFFFFFF) at g=GMAX passes unchanged.
REQ-026 Reversal: during FADE_IN at g=20, change select back to the old source. FADE_OUT starts at 20, and exactly 20 strobes later SWITCH occurs.
REQ-027 Dead source: in PLAY on src0, stop src0 strobes and set select=3.
- After 4096 clk the state is SWITCH and active_sel = 3.
- No out_valid occurs during the stall.
REQ-028 Disturbances:
- Drop run mid-FADE_OUT: out_valid stops within 1 clk and the state is IDLE.
- select=NUM_SRC: no state change.
- Assert reset_n mid-FADE_IN: all outputs are 0 immediately, with no clk edge.

Source files
------------

// File: rtl/audio_xfade_mux.sv
// Stereo PCM source selector that crossfades between sources with a per-sample gain ramp.
// The selected sample pair is scaled by a two-stage multiply / arithmetic-shift pipeline.
module audio_xfade_mux #(
    parameter int  NUM_SRC   = 4,
    parameter int  DATA_W    = 24,
    parameter int  RAMP_BITS = 6,
    parameter int  TIMEOUT   = 4096,
    localparam int SEL_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        run,
    input  logic [SEL_W-1:0]            select,
    input  logic [NUM_SRC-1:0]          src_valid,
    input  logic [NUM_SRC*DATA_W-1:0]   l_src_data,
    input  logic [NUM_SRC*DATA_W-1:0]   r_src_data,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           l_out,
    output logic [DATA_W-1:0]           r_out,
    output logic [SEL_W-1:0]            active_sel,
    output logic                        busy
);

    localparam int GAIN_W = RAMP_BITS + 1;
    localparam int PROD_W = DATA_W + RAMP_BITS + 2;
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    localparam logic [GAIN_W-1:0] GMAX      = {1'b1, {RAMP_BITS{1'b0}}};
    localparam logic [GAIN_W-1:0] GAIN_ONE  = {{(GAIN_W-1){1'b0}}, 1'b1};
    localparam logic [SEL_W:0]    NUM_SRC_V = (SEL_W+1)'(NUM_SRC);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]   TO_ONE    = {{(TO_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FADE_IN  = 3'd1,
        ST_PLAY     = 3'd2,
        ST_FADE_OUT = 3'd3,
        ST_SWITCH   = 3'd4
    } state_t;

    state_t                     state_r;
    state_t                     state_s;
    logic [GAIN_W-1:0]          gain_r;
    logic [GAIN_W-1:0]          gain_s;
    logic [SEL_W-1:0]           pending_sel_r;
    logic [SEL_W-1:0]           pending_sel_s;
    logic [SEL_W-1:0]           active_sel_s;
    logic [TO_W-1:0]            timeout_cnt_r;
    logic [TO_W-1:0]            timeout_cnt_s;
    logic                       busy_s;

    logic                       strobe_sel_s;
    logic [DATA_W-1:0]          l_sel_s;
    logic [DATA_W-1:0]          r_sel_s;
    logic                       strobe_s;
    logic                       sel_ok_s;
    logic                       sel_new_s;
    logic                       timeout_hit_s;

    logic signed [PROD_W-1:0]   l_prod_s;
    logic signed [PROD_W-1:0]   r_prod_s;
    logic signed [PROD_W-1:0]   l_prod_r;
    logic signed [PROD_W-1:0]   r_prod_r;
    logic                       prod_valid_r;
    logic [DATA_W-1:0]          l_scaled_s;
    logic [DATA_W-1:0]          r_scaled_s;

    // Route the active source's strobe and sample pair.
    always_comb begin
        strobe_sel_s = 1'b0;
        l_sel_s      = '0;
        r_sel_s      = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            strobe_sel_s = (active_sel == SEL_W'(k)) ? src_valid[k] : strobe_sel_s;
            l_sel_s      = (active_sel == SEL_W'(k)) ? l_src_data[k*DATA_W +: DATA_W] : l_sel_s;
            r_sel_s      = (active_sel == SEL_W'(k)) ? r_src_data[k*DATA_W +: DATA_W] : r_sel_s;
        end
    end

    // Strobes only count while a source is being faded or played.
    assign strobe_s      = run & strobe_sel_s &
                           ((state_r == ST_FADE_IN) | (state_r == ST_PLAY) | (state_r == ST_FADE_OUT));
    assign sel_ok_s      = ({1'b0, select} < NUM_SRC_V);
    assign sel_new_s     = sel_ok_s & (select != active_sel);
    assign timeout_hit_s = ~strobe_s & (timeout_cnt_r == TO_LAST);

    assign l_prod_s   = PROD_W'($signed(l_sel_s)) * PROD_W'($signed({1'b0, gain_r}));
    assign r_prod_s   = PROD_W'($signed(r_sel_s)) * PROD_W'($signed({1'b0, gain_r}));
    assign l_scaled_s = DATA_W'(l_prod_r >>> RAMP_BITS);
    assign r_scaled_s = DATA_W'(r_prod_r >>> RAMP_BITS);

    // Next-state, gain and selection logic; gain moves after the strobe has used it.
    always_comb begin
        state_s       = state_r;
        gain_s        = gain_r;
        active_sel_s  = active_sel;
        pending_sel_s = pending_sel_r;
        if (!run) begin
            state_s = ST_IDLE;
            gain_s  = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    gain_s = '0;
                    if (sel_ok_s) begin
                        state_s      = ST_FADE_IN;
                        active_sel_s = select;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_FADE_IN: begin
                    if (strobe_s && (gain_r != GMAX)) begin
                        gain_s = gain_r + GAIN_ONE;
                    end else begin
                        gain_s = gain_r;
                    end
                    if (sel_new_s) begin
                        state_s       = ST_FADE_OUT;
                        pending_sel_s = select;
                    end else if (gain_s == GMAX) begin
                        state_s = ST_PLAY;
                    end else if (timeout_hit_s) begin
                        state_s       = ST_SWITCH;
                        pending_sel_s = active_sel;
                    end else begin
                        state_s = ST_FADE_IN;
                    end
                end
                ST_PLAY: begin
                    if (sel_new_s) begin
                        state_s       = ST_FADE_OUT;
                        pending_sel_s = select;
                    end else begin
                        state_s = ST_PLAY;
                    end
                end
                ST_FADE_OUT: begin
                    if (strobe_s && (gain_r != '0)) begin
                        gain_s = gain_r - GAIN_ONE;
                    end else begin
                        gain_s = gain_r;
                    end
                    if (sel_new_s) begin
                        pending_sel_s = select;
                    end else begin
                        pending_sel_s = pending_sel_r;
                    end
                    // A return to the playing source resumes the fade-in from the current gain.
                    if (sel_ok_s && (select == active_sel)) begin
                        state_s = ST_FADE_IN;
                    end else if ((gain_s == '0) || timeout_hit_s) begin
                        state_s = ST_SWITCH;
                    end else begin
                        state_s = ST_FADE_OUT;
                    end
                end
                ST_SWITCH: begin
                    state_s      = ST_FADE_IN;
                    active_sel_s = pending_sel_r;
                    gain_s       = '0;
                end
                default: begin
                    state_s = ST_IDLE;
                    gain_s  = '0;
                end
            endcase
        end

        if (!run || (state_s != state_r) || strobe_s) begin
            timeout_cnt_s = '0;
        end else if ((state_r == ST_FADE_IN) || (state_r == ST_FADE_OUT)) begin
            timeout_cnt_s = timeout_cnt_r + TO_ONE;
        end else begin
            timeout_cnt_s = '0;
        end

        busy_s = (state_s != ST_PLAY) && (state_s != ST_IDLE);
    end

    // Control registers: state, gain, source selection, stall counter and busy flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            gain_r        <= '0;
            pending_sel_r <= '0;
            active_sel    <= '0;
            timeout_cnt_r <= '0;
            busy          <= 1'b0;
        end else begin
            state_r       <= state_s;
            gain_r        <= gain_s;
            pending_sel_r <= pending_sel_s;
            active_sel    <= active_sel_s;
            timeout_cnt_r <= timeout_cnt_s;
            busy          <= busy_s;
        end
    end

    // Scaling pipeline; dropping run discards in-flight samples but keeps the last output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            l_prod_r     <= '0;
            r_prod_r     <= '0;
            prod_valid_r <= 1'b0;
            out_valid    <= 1'b0;
            l_out        <= '0;
            r_out        <= '0;
        end else begin
            prod_valid_r <= strobe_s;
            out_valid    <= prod_valid_r & run;
            if (strobe_s) begin
                l_prod_r <= l_prod_s;
                r_prod_r <= r_prod_s;
            end else begin
                l_prod_r <= l_prod_r;
                r_prod_r <= r_prod_r;
            end
            if (prod_valid_r && run) begin
                l_out <= l_scaled_s;
                r_out <= r_scaled_s;
            end else begin
                l_out <= l_out;
                r_out <= r_out;
            end
        end
    end

endmodule
